regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter_if.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus bundle between the EX/MEM writeback paths, the decode
// hazard check and the register-file write port.
interface regfile_wb_arbiter_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;

    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;

    logic        ld_issue_valid;
    logic [4:0]  ld_issue_rd;

    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        hazard_stall;

    logic        RegWrite;
    logic [4:0]  WB_Rdaddr;
    logic [31:0] WB_Rddata;

    // Pipeline side: raises requests, sees handshakes and the write port.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output ld_issue_valid, ld_issue_rd,
        output dec_rs1, dec_rs2, dec_rd,
        input  alu_ready, lsu_ready, hazard_stall,
        input  RegWrite, WB_Rdaddr, WB_Rddata
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  ld_issue_valid, ld_issue_rd,
        input  dec_rs1, dec_rs2, dec_rd,
        output alu_ready, lsu_ready, hazard_stall,
        output RegWrite, WB_Rdaddr, WB_Rddata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU results have priority, load results
// wait in a small FIFO and win once they have lost too many cycles in a row.
// Also tracks destinations of outstanding loads so decode can stall on them.
module regfile_wb_arbiter #(
    parameter int LSU_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int PTR_W = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam int CNT_W = $clog2(LSU_DEPTH + 1);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LSU_DEPTH);
    localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(STARVE_LIMIT);

    logic [4:0]       fifo_rd   [LSU_DEPTH];
    logic [31:0]      fifo_data [LSU_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [AGE_W-1:0] age;
    logic [31:0]      pend;
    logic [31:0]      pend_next;

    logic        fifo_empty;
    logic        fifo_full;
    logic        lsu_prio;
    logic        lsu_grant;
    logic        alu_grant;
    logic        enq;
    logic [4:0]  head_rd;
    logic [31:0] head_data;

    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    // Grant decision for this cycle; the FIFO is judged on its registered
    // occupancy, so a freshly accepted load can never be granted the same cycle.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == DEPTH_C);
        lsu_prio   = (age >= LIMIT_C);
        head_rd    = fifo_rd[rd_ptr];
        head_data  = fifo_data[rd_ptr];
        lsu_grant  = !fifo_empty && (!bus.alu_valid || lsu_prio);
        alu_grant  = bus.alu_valid && !lsu_grant;
        enq        = bus.lsu_valid && !fifo_full;
    end

    assign bus.lsu_ready    = !fifo_full;
    assign bus.alu_ready    = !(!fifo_empty && lsu_prio);
    assign bus.hazard_stall = pend[bus.dec_rs1] | pend[bus.dec_rs2] | pend[bus.dec_rd];
    assign bus.RegWrite     = wb_we;
    assign bus.WB_Rdaddr    = wb_addr;
    assign bus.WB_Rddata    = wb_data;

    // FIFO storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_rd[wr_ptr]   <= bus.lsu_rd;
            fifo_data[wr_ptr] <= bus.lsu_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (lsu_grant) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(enq) - CNT_W'(lsu_grant);
        end
    end

    // Aging counter: counts cycles a waiting load lost to the ALU, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            age <= '0;
        end else if (fifo_empty || lsu_grant) begin
            age <= '0;
        end else if (alu_grant && (age != LIMIT_C)) begin
            age <= age + AGE_W'(1);
        end
    end

    // Next scoreboard value: a new load issue beats a same-register completion.
    always_comb begin
        pend_next = pend;
        if (lsu_grant) begin
            pend_next[head_rd] = 1'b0;
        end
        if (bus.ld_issue_valid && (bus.ld_issue_rd != 5'd0)) begin
            pend_next[bus.ld_issue_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend <= pend_next;
        end
    end

    // Registered write port; x0 writes consume their slot but never enable the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_addr <= 5'd0;
            wb_data <= 32'd0;
        end else if (lsu_grant) begin
            wb_we   <= (head_rd != 5'd0);
            wb_addr <= head_rd;
            wb_data <= head_data;
        end else if (alu_grant) begin
            wb_we   <= (bus.alu_rd != 5'd0);
            wb_addr <= bus.alu_rd;
            wb_data <= bus.alu_data;
        end else begin
            wb_we <= 1'b0;
        end
    end
endmodule
